voice_allocator: RTL

Polyphony controller for the synth voice bank. It accepts serialized note-on/note-off events and assigns each note-on to one of NUM_VOICES envelope voices. It drives each voice's gate (the envelope's note_in) and note number, and steals the oldest voice when all voices are busy. It sits between the keyboard/MIDI event decoder and the per-voice envelope_filter + oscillator instances.

---
 rtl/synth_pkg.sv | 10 +
 rtl/voice_allocator_if.sv | 14 +
 rtl/voice_age_tracker.sv | 61 ++++++
 rtl/voice_allocator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types for the synth voice bank: allocator FSM states and candidate classes.
package synth_pkg;

    localparam int unsigned DefNoteW = 7;

    typedef enum logic [1:0] {StIdle, StScan, StCommit, StSteal} alloc_state_e;

    typedef enum logic [1:0] {ClsMatch, ClsFree, ClsRel, ClsOld} cand_cls_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Serialized note event channel from the event decoder into the voice allocator.
interface voice_allocator_if
    import synth_pkg::*;
#(
    parameter int unsigned NOTE_W = DefNoteW
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;

    modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
    modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_age_tracker.sv
// Saturating per-voice age counters with a clear-one / bump-others update and an
// oldest-gated-voice comparator (ties resolve to the lowest index).
module voice_age_tracker
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 4,
    localparam int unsigned IdxW      = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_VOICES-1:0] gate_i,
    input  logic                  clr_en_i,
    input  logic                  inc_en_i,
    input  logic [IdxW-1:0]       sel_idx_i,
    output logic [IdxW-1:0]       oldest_idx_o
);
    localparam logic [AGE_W-1:0] AgeMax = '1;

    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [AGE_W-1:0] age_d [NUM_VOICES];
    logic [AGE_W-1:0] best_age;
    logic             best_vld;

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            age_d[i] = age_q[i];
            if (inc_en_i && gate_i[i] && (IdxW'(i) != sel_idx_i) && (age_q[i] != AgeMax)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
            if (clr_en_i && (IdxW'(i) == sel_idx_i)) begin
                age_d[i] = '0;
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        oldest_idx_o = '0;
        best_age     = '0;
        best_vld     = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (gate_i[i] && (!best_vld || (age_q[i] > best_age))) begin
                best_vld     = 1'b1;
                best_age     = age_q[i];
                oldest_idx_o = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (reset) begin
                age_q[i] <= '0;
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: scans the voice bank once per event, then assigns, releases
// or steals a voice (oldest gated voice when nothing is free).
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_W     = DefNoteW,
    parameter int unsigned AGE_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    voice_allocator_if.slave             ev,
    input  logic [NUM_VOICES-1:0]        voice_idle,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_kill
);
    localparam int unsigned IdxW = $clog2(NUM_VOICES);

    alloc_state_e      state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              on_q, on_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] kill_q, kill_d;
    logic [NOTE_W-1:0] vnote_q [NUM_VOICES];
    logic [NOTE_W-1:0] vnote_d [NUM_VOICES];
    logic [IdxW-1:0]   steal_idx_q, steal_idx_d;
    logic              match_vld_q, match_vld_d, free_vld_q, free_vld_d, rel_vld_q, rel_vld_d;
    logic [IdxW-1:0]   match_idx_q, match_idx_d, free_idx_q, free_idx_d, rel_idx_q, rel_idx_d;

    logic              age_clr, age_inc;
    logic [IdxW-1:0]   age_sel, oldest_idx, tgt;
    cand_cls_e         cls;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W)
    ) u_age_tracker (
        .clk          (clk),
        .reset        (reset),
        .gate_i       (gate_q),
        .clr_en_i     (age_clr),
        .inc_en_i     (age_inc),
        .sel_idx_i    (age_sel),
        .oldest_idx_o (oldest_idx)
    );

    assign ev.ev_ready  = (state_q == StIdle) && !reset;
    assign voice_gate   = gate_q;
    assign voice_kill   = kill_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = vnote_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        on_d        = on_q;
        ev_note_d   = ev_note_q;
        gate_d      = gate_q;
        kill_d      = '0;
        vnote_d     = vnote_q;
        steal_idx_d = steal_idx_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        rel_vld_d   = rel_vld_q;
        rel_idx_d   = rel_idx_q;
        age_clr     = 1'b0;
        age_inc     = 1'b0;
        age_sel     = '0;
        cls         = ClsOld;
        tgt         = '0;

        unique case (state_q)
            StIdle: begin
                if (ev.ev_valid) begin
                    on_d        = ev.ev_on;
                    ev_note_d   = ev.ev_note;
                    idx_d       = '0;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    rel_vld_d   = 1'b0;
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (gate_q[idx_q] && (vnote_q[idx_q] == ev_note_q) && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!gate_q[idx_q] && voice_idle[idx_q] && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                if (!gate_q[idx_q] && !voice_idle[idx_q] && !rel_vld_q) begin
                    rel_vld_d = 1'b1;
                    rel_idx_d = idx_q;
                end
                if (idx_q == IdxW'(NUM_VOICES - 1)) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (!on_q) begin
                    if (match_vld_q) begin
                        gate_d[match_idx_q] = 1'b0;
                    end
                end else begin
                    if (match_vld_q) begin
                        cls = ClsMatch;
                        tgt = match_idx_q;
                    end else if (free_vld_q) begin
                        cls = ClsFree;
                        tgt = free_idx_q;
                    end else if (rel_vld_q) begin
                        cls = ClsRel;
                        tgt = rel_idx_q;
                    end else begin
                        cls = ClsOld;
                        tgt = oldest_idx;
                    end
                    age_clr = 1'b1;
                    age_inc = 1'b1;
                    age_sel = tgt;
                    unique case (cls)
                        ClsMatch: ;
                        ClsFree, ClsRel: begin
                            gate_d[tgt]  = 1'b1;
                            vnote_d[tgt] = ev_note_q;
                        end
                        ClsOld: begin
                            kill_d[tgt]  = 1'b1;
                            gate_d[tgt]  = 1'b0;
                            vnote_d[tgt] = ev_note_q;
                            steal_idx_d  = tgt;
                            state_d      = StSteal;
                        end
                    endcase
                end
            end
            StSteal: begin
                gate_d[steal_idx_q] = 1'b1;
                state_d             = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            on_q        <= 1'b0;
            ev_note_q   <= '0;
            gate_q      <= '0;
            kill_q      <= '0;
            steal_idx_q <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            rel_vld_q   <= 1'b0;
            rel_idx_q   <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            on_q        <= on_d;
            ev_note_q   <= ev_note_d;
            gate_q      <= gate_d;
            kill_q      <= kill_d;
            steal_idx_q <= steal_idx_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            rel_vld_q   <= rel_vld_d;
            rel_idx_q   <= rel_idx_d;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i] <= vnote_d[i];
            end
        end
    end

endmodule
